// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e     - frame-sequencer states
//   PARITY_MODE_*    - values for the PARITY_ODD parameter
//   clks_per_bit()   - system clocks per line bit for a given clock/baud pair
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // Integer divide: any fractional remainder becomes a small baud error.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter.
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   clear  - hold the counter at zero (restarts the bit period)
//   tick   - high during the last clock of each CLKS_PER_BIT-long period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, whatever the block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit framer.
// Accepts a byte over valid/ready and shifts it out LSB-first as
// start / data / optional parity / stop bits at CLK_FREQ/BAUD clocks per bit.
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   tx_data   - byte to send, sampled on handshake
//   tx_valid  - source has a byte
//   tx_ready  - serializer accepts a byte this cycle
//   tx        - serial line, idle high
//   busy      - a frame is on the line
//   tx_done   - one-cycle pulse in the first idle cycle after the last stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam bit         ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 parity_bit;
  logic                 tick;

  // Every state entry other than from IDLE happens on a tick, where the
  // counter wraps to zero by itself; holding it cleared in IDLE covers the
  // start bit.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift      <= tx_data;
            // Parity is taken from the byte as accepted, since the shift
            // register is consumed by the time the parity bit is sent.
            parity_bit <= (^tx_data) ^ ODD_MODE;
            bit_idx    <= '0;
            state      <= START;
            tx         <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              // tx is registered, so load the bit that becomes shift[0]
              // after this shift.
              tx      <= shift[1];
            end
          end
        end

        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx  <= '0;
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer. Four instances share clk/rst/tx_data:
//   0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, all at 10 clocks per bit.
// Expected line levels come from a frame model built from the byte value.
module tb_uart_tx_serializer;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] valid_l;
  logic [3:0] tx_l, ready_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_l[0]),
    .tx_ready(ready_l[0]), .tx(tx_l[0]), .busy(busy_l[0]), .tx_done(done_l[0]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_l[1]),
    .tx_ready(ready_l[1]), .tx(tx_l[1]), .busy(busy_l[1]), .tx_done(done_l[1]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_l[2]),
    .tx_ready(ready_l[2]), .tx(tx_l[2]), .busy(busy_l[2]), .tx_done(done_l[2]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_l[3]),
    .tx_ready(ready_l[3]), .tx(tx_l[3]), .busy(busy_l[3]), .tx_done(done_l[3]));

  // ---------------- reference model ----------------
  function automatic bit has_parity(int i);
    return (i == 1) || (i == 2);
  endfunction

  function automatic bit odd_parity(int i);
    return (i == 2);
  endfunction

  function automatic int stop_bits(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_periods(int i);
    return 1 + 8 + (has_parity(i) ? 1 : 0) + stop_bits(i);
  endfunction

  // Line level during bit period p of a frame carrying b.
  function automatic logic model_level(int i, logic [7:0] b, int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (has_parity(i) && p == 9) return logic'(($countones(b) % 2) == 1) ^ odd_parity(i);
    return 1'b1;
  endfunction

  // ---------------- frame helpers (begin and end on a falling edge) ----------------
  task automatic start_frame(int i, logic [7:0] b);
    int w = 0;
    while (ready_l[i] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ready_l[i] !== 1'b1) begin
      errors++;
      $display("FAIL start_ready inst %0d: tx_ready=%b required 1", i, ready_l[i]);
    end
    tx_data    = b;
    valid_l[i] = 1'b1;
    @(negedge clk);
  endtask

  // Observes a whole frame from its first start-bit cycle, then the first
  // idle cycle. poke_cycle >= 0 pulses tx_valid with 0xFF mid-frame;
  // hold_valid keeps tx_valid high and swaps tx_data to next_data.
  task automatic check_frame(int i, logic [7:0] b, int poke_cycle,
                             bit hold_valid, logic [7:0] next_data);
    int cyc = 0;
    bit ok_busy = 1'b1, ok_ready = 1'b1, ok_done = 1'b1;
    for (int p = 0; p < frame_periods(i); p++) begin
      logic exp_l = model_level(i, b, p);
      logic obs_l = exp_l;
      int   bad_at = -1;
      for (int c = 0; c < N; c++) begin
        if (cyc > 0) @(negedge clk);
        if (cyc == 0) begin
          if (hold_valid) tx_data = next_data;
          else valid_l[i] = 1'b0;
        end
        if (poke_cycle >= 0 && cyc == poke_cycle) begin
          tx_data    = 8'hFF;
          valid_l[i] = 1'b1;
        end
        if (poke_cycle >= 0 && cyc == poke_cycle + 1) valid_l[i] = 1'b0;
        if (tx_l[i] !== exp_l && bad_at < 0) begin
          obs_l  = tx_l[i];
          bad_at = cyc;
        end
        if (busy_l[i] !== 1'b1) ok_busy = 1'b0;
        if (ready_l[i] !== 1'b0) ok_ready = 1'b0;
        if (done_l[i] !== 1'b0) ok_done = 1'b0;
        cyc++;
      end
      checks++;
      if (bad_at >= 0) begin
        errors++;
        $display("FAIL frame_bit inst %0d byte %h period %0d cycle %0d: tx=%b required %b",
                 i, b, p, bad_at, obs_l, exp_l);
      end
    end
    checks++;
    if (!ok_busy) begin
      errors++;
      $display("FAIL frame_busy inst %0d byte %h: busy=0 seen, required 1 throughout", i, b);
    end
    checks++;
    if (!ok_ready) begin
      errors++;
      $display("FAIL frame_ready inst %0d byte %h: tx_ready=1 seen, required 0 throughout", i, b);
    end
    checks++;
    if (!ok_done) begin
      errors++;
      $display("FAIL frame_done_early inst %0d byte %h: tx_done=1 seen, required 0 in frame", i, b);
    end
    @(negedge clk);
    checks++;
    if (done_l[i] !== 1'b1 || ready_l[i] !== 1'b1 || busy_l[i] !== 1'b0 || tx_l[i] !== 1'b1) begin
      errors++;
      $display("FAIL frame_end inst %0d byte %h: done/ready/busy/tx=%b%b%b%b required 1101",
               i, b, done_l[i], ready_l[i], busy_l[i], tx_l[i]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst     = 1'b1;
    valid_l = '0;
    tx_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_l !== 4'hF || ready_l !== 4'h0 || busy_l !== 4'h0 || done_l !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: tx=%b ready=%b busy=%b done=%b required 1111/0000/0000/0000",
               tx_l, ready_l, busy_l, done_l);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_l !== 4'hF || tx_l !== 4'hF || done_l !== 4'h0) begin
      errors++;
      $display("FAIL reset_release: ready=%b tx=%b done=%b required 1111/1111/0000",
               ready_l, tx_l, done_l);
    end
  endtask

  task automatic test_8n1();
    start_frame(0, 8'h55);
    check_frame(0, 8'h55, -1, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    start_frame(1, 8'hA5);
    check_frame(1, 8'hA5, -1, 1'b0, 8'h00);
    start_frame(2, 8'hA5);
    check_frame(2, 8'hA5, -1, 1'b0, 8'h00);
    start_frame(1, 8'h07);
    check_frame(1, 8'h07, -1, 1'b0, 8'h00);
  endtask

  task automatic test_stop2();
    start_frame(3, 8'h00);
    check_frame(3, 8'h00, -1, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h0F);
    check_frame(0, 8'h0F, -1, 1'b1, 8'hF0);
    // valid still high: accepted at this idle cycle's edge, so the next
    // cycle must already be the second start bit.
    @(negedge clk);
    check_frame(0, 8'hF0, -1, 1'b0, 8'h00);
  endtask

  task automatic test_ignore_busy();
    bit quiet = 1'b1;
    start_frame(0, 8'h96);
    check_frame(0, 8'h96, 35, 1'b0, 8'h00);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_l[0] !== 1'b1 || busy_l[0] !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL ignore_busy: second frame started, required line idle after first frame");
    end
  endtask

  task automatic test_reset_mid_frame();
    bit no_done = 1'b1;
    start_frame(0, 8'h3C);
    valid_l[0] = 1'b0;
    for (int c = 1; c <= 44; c++) @(negedge clk);   // inside data bit 3
    checks++;
    if (tx_l[0] !== model_level(0, 8'h3C, 4) || busy_l[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: tx=%b busy=%b required %b/1", tx_l[0], busy_l[0],
               model_level(0, 8'h3C, 4));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_l[0] !== 1'b1 || busy_l[0] !== 1'b0 || ready_l[0] !== 1'b0 || done_l[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx/busy/ready/done=%b%b%b%b required 1000",
               tx_l[0], busy_l[0], ready_l[0], done_l[0]);
    end
    @(negedge clk);
    if (done_l[0] !== 1'b0) no_done = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    if (done_l[0] !== 1'b0) no_done = 1'b0;
    checks++;
    if (!no_done) begin
      errors++;
      $display("FAIL reset_no_done: tx_done=1 seen, required 0 after abandoned frame");
    end
    checks++;
    if (ready_l[0] !== 1'b1 || tx_l[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: ready=%b tx=%b required 1/1", ready_l[0], tx_l[0]);
    end
    start_frame(0, 8'h81);
    check_frame(0, 8'h81, -1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int         i = int'($urandom_range(0, 3));
      logic [7:0] b = 8'($urandom);
      start_frame(i, b);
      check_frame(i, b, -1, 1'b0, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the UART link; the serial-frame generator that drives the line the receiver samples.
- Accepts parallel bytes over a valid/ready handshake and shifts them out LSB-first as start / data / optional parity / stop frames at a fixed baud rate.
- Sits between the system byte source (loopback of received bytes or command logic) and the tx pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 434 at defaults); elaboration error if CLKS_PER_BIT < 2.
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts one parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  in  1  source has a byte.
- tx_ready  out  1  serializer can accept a byte this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse at end of the last stop bit.

Behaviour:
- Reset (async assert, sync release) values:
  - tx=1, tx_ready=0, busy=0, tx_done=0.
  - State IDLE; baud counter, bit index and shift register cleared.
  - tx_ready rises on the first clk edge after rst deasserts.
- Reset mid-frame: tx returns to 1 immediately; the partial frame is abandoned and no tx_done is produced.
- All outputs are registered.
- Handshake:
  - Accept when tx_valid & tx_ready on a rising edge. tx_data is latched into the shift register and tx_ready drops the same edge.
  - tx_valid while tx_ready=0 is ignored; no queuing.
  - tx_data changes while busy have no effect on the frame in progress.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - IDLE: tx=1, tx_ready=1, busy=0.
  - START: tx=0 for CLKS_PER_BIT cycles, starting the cycle after acceptance (latency 1 clk from handshake to falling edge). busy=1.
  - DATA: DATA_BITS bit periods, shift register bit 0 driven, shift right per period, bit index 0..DATA_BITS-1.
  - PARITY: one bit period, tx = XOR of latched data bits, inverted if PARITY_ODD.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, reloads to 0 on every state entry; terminal count advances bit/state.
  - Width $clog2(CLKS_PER_BIT).
- Frame end:
  - On the last stop-bit terminal count, next state is IDLE.
  - The first IDLE cycle has tx_done=1 and tx_ready=1.
  - Frame length is exactly (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from the falling start edge.
- Back-to-back: tx_valid held high is accepted in the first IDLE cycle, giving exactly 1 clk of extra idle-high between frames.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), a clks_per_bit(CLK_FREQ,BAUD) function, and parity-mode constants. The receiver shares the package.
- Sub-module uart_baud_gen: counter with clear and terminal-count tick, parameterised by CLKS_PER_BIT. It is reusable by the receiver at 16x oversampling.

Test Plan:
- CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10), 8N1, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 each held 10 clks; tx_done at cycle 100 after the start edge; tx_ready back the same cycle.
- PARITY_EN=1, even, send 0xA5 -> parity bit 0 after data 1,0,1,0,0,1,0,1. With PARITY_ODD=1 -> parity bit 1; frame 110 clks.
- tx_valid held high with 0x0F then 0xF0 -> two frames separated by exactly 1 idle clk; second frame data LSB-first 0,0,0,0,1,1,1,1.
- Assert rst during data bit 3 of 0x3C -> tx=1 same cycle (async); no tx_done; after release tx_ready=1 next edge; new byte 0x81 framed correctly.
- Pulse tx_valid with 0xFF while busy mid-frame -> ignored; original byte completes; no second frame.
- STOP_BITS=2, send 0x00 -> tx high for 20 clks after data; tx_done after 110 clks.
